// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping slice.
//   state_t   : FSM encoding, also presented on the mode output
//   *_MAX     : BCD wrap limits for the hour, minute and second fields
//   bcd_digit : one 4-bit BCD digit
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  typedef logic [3:0] bcd_digit;

endpackage

// File: rtl/clock_timekeeper_bcd.sv
// Two-digit BCD modulo counter, wrapping from MAX back to 00.
// Ports:
//   clk   : clock, posedge
//   clr_n : synchronous active-low clear to 00
//   inc   : advance by one this cycle
//   value : {tens, units} in BCD
//   carry : combinational, high when inc arrives while value == MAX
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  bcd_digit tens;
  bcd_digit units;

  assign value = {tens, units};
  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (value == MAX) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour BCD timekeeper with a 1 Hz prescaler and a button-driven set mode.
// Ports:
//   clk, clr          : clock and synchronous active-low reset
//   btn_mode, btn_inc : debounced, synchronised level buttons
//   hour_t..min_u     : registered BCD digits for the display driver
//   sec_bcd           : registered BCD seconds {tens, units}
//   colon             : first half of each second in RUN, steady 1 in set mode
//   blank             : [1] blanks hour digits, [0] blanks minute digits
//   mode              : current FSM state (RUN / SET_HOUR / SET_MIN)
// Button handshake: each rising edge of a button level (btn & ~btn_q) is a
// single request consumed in that cycle; a held level produces nothing more.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_t,
  output logic [3:0] hour_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [7:0] sec_bcd,
  output logic       colon,
  output logic [1:0] blank,
  output logic [1:0] mode
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] PRE_TOP  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE_HALF = CW'(TICK_DIV / 2);
  localparam logic [BW-1:0] BLK_TOP  = BW'(BLINK_DIV - 1);

  state_t        state, state_next;
  logic          mode_q, inc_q;
  logic          mode_edge, inc_edge;
  logic [CW-1:0] pre_cnt;
  logic          tick;
  logic [BW-1:0] blk_cnt;
  logic          blk_phase;
  logic          set_hour_inc, set_min_inc, sec_clear;
  logic          sec_carry, min_carry, hour_carry_unused;
  logic          min_inc, hour_inc;
  logic [7:0]    sec_val, min_val, hour_val;

  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc & ~inc_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!clr) state <= RUN;
    else      state <= state_next;
  end

  // FSM next state and set-mode actions; mode edge always beats inc edge
  always_comb begin
    state_next   = state;
    set_hour_inc = 1'b0;
    set_min_inc  = 1'b0;
    sec_clear    = 1'b0;
    unique case (state)
      RUN: begin
        if (mode_edge) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_edge)     state_next   = SET_MIN;
        else if (inc_edge) set_hour_inc = 1'b1;
      end
      SET_MIN: begin
        if (mode_edge) begin
          state_next = RUN;
          sec_clear  = 1'b1;
        end else if (inc_edge) begin
          set_min_inc = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Prescaler only runs in RUN, so the first second after leaving set
  // mode is a full second.
  always_ff @(posedge clk) begin
    if (!clr || state != RUN) pre_cnt <= '0;
    else if (pre_cnt == PRE_TOP) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (state == RUN) && (pre_cnt == PRE_TOP);

  // Blink restarts from phase 0 on every state entry.
  always_ff @(posedge clk) begin
    if (!clr || state == RUN || state_next != state) begin
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
    end else if (blk_cnt == BLK_TOP) begin
      blk_cnt   <= '0;
      blk_phase <= ~blk_phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  // In set mode the upstream carries are idle (no tick), so the FSM
  // increments take their place.
  assign min_inc  = (state == RUN) ? sec_carry : set_min_inc;
  assign hour_inc = (state == RUN) ? min_carry : set_hour_inc;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .clr_n (clr & ~sec_clear),
    .inc   (tick),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .clr_n (clr),
    .inc   (min_inc),
    .value (min_val),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .clr_n (clr),
    .inc   (hour_inc),
    .value (hour_val),
    .carry (hour_carry_unused)
  );

  assign hour_t  = hour_val[7:4];
  assign hour_u  = hour_val[3:0];
  assign min_t   = min_val[7:4];
  assign min_u   = min_val[3:0];
  assign sec_bcd = sec_val;
  assign mode    = state;
  assign colon   = (state == RUN) ? (pre_cnt < PRE_HALF) : 1'b1;
  assign blank   = {(state == SET_HOUR) & blk_phase, (state == SET_MIN) & blk_phase};

endmodule

// File: tb/tb_clock_timekeeper.sv
module tb_clock_timekeeper;

  localparam int TD = 10;
  localparam int BD = 4;
  localparam int W  = 29;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] hour_t, hour_u, min_t, min_u;
  logic [7:0] sec_bcd;
  logic       colon;
  logic [1:0] blank, mode;

  clock_timekeeper #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour_t   (hour_t),
    .hour_u   (hour_u),
    .min_t    (min_t),
    .min_u    (min_u),
    .sec_bcd  (sec_bcd),
    .colon    (colon),
    .blank    (blank),
    .mode     (mode)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;
  logic [W-1:0] exp_q[$];

  // behavioural reference, plain integers
  int   m_state = 0, m_pre = 0, m_h = 0, m_m = 0, m_s = 0, m_bc = 0, m_ph = 0;
  logic m_modeq = 1'b0, m_incq = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic c;
    logic [1:0] b;
    c = (m_state == 0) ? (m_pre < TD / 2) : 1'b1;
    b = {(m_state == 1) && (m_ph != 0), (m_state == 2) && (m_ph != 0)};
    return {bcd(m_h), bcd(m_m), bcd(m_s), 2'(m_state), c, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int ns;
    logic me, ie;
    if (!clr) begin
      m_state = 0; m_pre = 0; m_h = 0; m_m = 0; m_s = 0;
      m_bc = 0; m_ph = 0; m_modeq = 1'b0; m_incq = 1'b0;
    end else begin
      me = btn_mode && !m_modeq;
      ie = btn_inc && !m_incq;
      ns = m_state;
      case (m_state)
        0: begin
          if (m_pre == TD - 1) begin
            m_pre = 0;
            m_s++;
            if (m_s == 60) begin
              m_s = 0;
              m_m++;
              if (m_m == 60) begin
                m_m = 0;
                m_h = (m_h + 1) % 24;
              end
            end
          end else begin
            m_pre++;
          end
          if (me) ns = 1;
        end
        1: begin
          m_pre = 0;
          if (me) ns = 2;
          else if (ie) m_h = (m_h + 1) % 24;
        end
        default: begin
          m_pre = 0;
          if (me) begin
            ns = 0;
            m_s = 0;
          end else if (ie) begin
            m_m = (m_m + 1) % 60;
          end
        end
      endcase
      if (ns != m_state || m_state == 0) begin
        m_bc = 0;
        m_ph = 0;
      end else if (m_bc == BD - 1) begin
        m_bc = 0;
        m_ph = 1 - m_ph;
      end else begin
        m_bc++;
      end
      m_state = ns;
      m_modeq = btn_mode;
      m_incq  = btn_inc;
    end
  endtask

  // driver: one clock with scoreboard push/pop around it
  task automatic step();
    logic [W-1:0] exp;
    model_update();
    exp_q.push_back(model_vec());
    @(negedge clk);
    exp = exp_q.pop_front();
    chk("cycle", 32'({hour_t, hour_u, min_t, min_u, sec_bcd, mode, colon, blank}), 32'(exp));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step();
    btn_inc = 1'b0; step();
  endtask

  task automatic run_until(input int h, input int m, input int s);
    int n;
    n = 0;
    while (!(m_h == h && m_m == m && m_s == s) && n < 3000) begin
      step();
      n++;
    end
    chk("run_until_bound", 32'(n < 3000), 32'd1);
  endtask

  task automatic chk_time(input string tag, input logic [23:0] t);
    chk(tag, 32'({hour_t, hour_u, min_t, min_u, sec_bcd}), 32'(t));
  endtask

  initial begin
    // 1. reset
    clr = 1'b0;
    steps(3);
    chk_time("reset_time", 24'h000000);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_colon", 32'(colon), 32'd1);
    chk("reset_blank", 32'(blank), 32'd0);
    clr = 1'b1;
    steps(10);
    chk("first_second", 32'(sec_bcd), 32'h01);

    // 2. set 23:59 then roll over
    press_mode();
    chk("enter_set_hour", 32'(mode), 32'd1);
    repeat (23) press_inc();
    chk("hour_23", 32'({hour_t, hour_u}), 32'h23);
    press_mode();
    chk("enter_set_min", 32'(mode), 32'd2);
    repeat (59) press_inc();
    chk("min_59", 32'({min_t, min_u}), 32'h59);
    press_mode();
    chk("exit_run", 32'(mode), 32'd0);
    chk_time("exit_time", 24'h235900);
    run_until(23, 59, 58);
    chk_time("pre_roll_58", 24'h235958);
    run_until(23, 59, 59);
    chk_time("pre_roll_59", 24'h235959);
    steps(9);
    chk_time("hold_59", 24'h235959);
    step();
    chk_time("rollover", 24'h000000);

    // 3. set hour from 22:xx
    press_mode();
    repeat (22) press_inc();
    press_mode();
    repeat (59) press_inc();
    press_mode();
    run_until(22, 59, 3);
    chk_time("at_225903", 24'h225903);
    press_mode();
    chk("set_hour_mode", 32'(mode), 32'd1);
    press_inc();
    chk_time("hour_inc_23", 24'h235903);
    press_inc();
    chk_time("hour_wrap_00", 24'h005903);
    steps(50);
    chk_time("frozen", 24'h005903);
    chk("set_colon", 32'(colon), 32'd1);

    // 4. set minute, wrap, exit
    press_mode();
    chk("set_min_mode", 32'(mode), 32'd2);
    press_inc();
    chk_time("min_wrap_00", 24'h000003);
    press_mode();
    chk("back_run", 32'(mode), 32'd0);
    chk_time("sec_cleared", 24'h000000);

    // 5. held button, then collision
    press_mode();
    btn_inc = 1'b1;
    steps(30);
    btn_inc = 1'b0;
    step();
    chk_time("held_once", 24'h010000);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step();
    chk("collide_mode", 32'(mode), 32'd2);
    chk_time("collide_no_inc", 24'h010000);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();

    // 6. blink in SET_MIN, then reset mid-set
    steps(2);
    chk("blink_e3", 32'(blank), 32'b00);
    step();
    chk("blink_e4", 32'(blank), 32'b01);
    steps(3);
    chk("blink_e7", 32'(blank), 32'b01);
    step();
    chk("blink_e8", 32'(blank), 32'b00);
    clr = 1'b0;
    step();
    chk_time("midset_reset_time", 24'h000000);
    chk("midset_reset_mode", 32'(mode), 32'd0);
    chk("midset_reset_blank", 32'(blank), 32'd0);
    chk("midset_reset_colon", 32'(colon), 32'd1);
    clr = 1'b1;
    steps(5);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Timekeeping stage of the FPGA digital clock. It sits directly upstream of the four-digit seven-segment driver.
- Divides the board clock to a 1 Hz tick and keeps 24-hour time (HH:MM:SS) in BCD.
- Supports a button-driven set mode.
- Presents four BCD digits (hour tens, hour units, minute tens, minute units) for the driver's in1..in4 inputs, plus a blinking-colon/seconds indicator.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1 s tick; must be ≥2. Counter width = $clog2(TICK_DIV).
- BLINK_DIV, 25000000, clk cycles per set-mode blink half-period; must be ≥2.

Ports:
- clk  input  1  board clock; all logic on posedge clk.
- clr  input  1  reset, synchronous, active-low; sampled on posedge clk.
- btn_mode  input  1  mode button, already debounced and synchronised, level.
- btn_inc  input  1  increment button, already debounced and synchronised, level.
- hour_t  output  4  BCD hour tens, 0..2 (to in1).
- hour_u  output  4  BCD hour units, 0..9 (to in2).
- min_t  output  4  BCD minute tens, 0..5 (to in3).
- min_u  output  4  BCD minute units, 0..9 (to in4).
- sec_bcd  output  8  BCD seconds, {tens,units}, 00..59.
- colon  output  1  high during the first half of each second in RUN.
- blank  output  2  [1]=blank hour digits, [0]=blank minute digits (set-mode blink).
- mode  output  2  current FSM state encoding.

Behaviour:
Reset (clr==0 at a posedge):
- Time = 00:00:00, state = RUN.
- Prescaler = 0, blink counter = 0, blink phase = 0.
- Edge-detect registers = 0.
- Outputs: all digits 0, colon=1, blank=00, mode=RUN.
- Reset takes priority over every other event, including during set mode.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps.
- tick is a 1-cycle pulse when the count equals TICK_DIV-1.
- colon = (count < TICK_DIV/2) in RUN, 1 in set states.

Button edges:
- Rising edge is detected as btn & ~btn_q (one registered stage).
- Each press acts exactly once. A held button does not repeat.

FSM states: RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2.
- RUN: seconds advance on tick. mode edge → SET_HOUR. inc edge ignored.
- SET_HOUR: time frozen and prescaler held at 0. inc edge → hour+1. mode edge → SET_MIN.
- SET_MIN: time frozen and prescaler held at 0. inc edge → minute+1. mode edge → RUN, and seconds cleared to 00 on that same cycle.
- Simultaneous mode and inc edges: mode wins; inc is discarded.

Time arithmetic (RUN, on tick, all BCD, carry within the same cycle):
- sec_u 9→0 carries to sec_t. sec_t:sec_u 59→00 carries to minutes.
- min 59→00 carries to hours. hour 23→00 wraps, no day output.
- Example: 23:59:59 + tick → 00:00:00 in a single cycle.

Set increments:
- Hour wraps 23→00. Minute wraps 59→00.
- No carry between fields in set mode. Seconds untouched until leaving SET_MIN.

Blink:
- Blink counter runs only in set states; toggles blink phase every BLINK_DIV cycles.
- Phase and counter reset to 0 on every state entry.
- blank[1] = phase in SET_HOUR, blank[0] = phase in SET_MIN, 00 in RUN.

Latency and validity:
- Digit outputs are registered and change one cycle after the causing tick or edge.
- Digits are always valid BCD in range. No illegal BCD value is reachable.

Decomposition:
- Shared package clock_pkg holds:
  - state localparams (RUN, SET_HOUR, SET_MIN);
  - BCD limits (HOUR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59);
  - the bcd_digit typedef (4 bits).
- One natural sub-module, bcd_mod_counter: a two-digit BCD counter with parameterised max (8'h59 / 8'h23). Ports: inc, clr_n sync, value, carry (carry = inc && value==max).
  - Instantiated three times: sec, min, hour.
  - In set mode, min and hour take inc from the FSM instead of from the upstream carry.

Test Plan (TICK_DIV=10, BLINK_DIV=4):
1. Reset: hold clr=0 3 cycles, release → 00:00:00, mode=0, colon=1, blank=00; after 10 cycles sec_bcd=8'h01.
2. Rollover: advance to 23:59:58, apply 2 ticks → 23:59:59 then 00:00:00 one cycle after the second tick, with all digits changing in the same cycle.
3. Set hour: from 22:xx press mode, then inc twice → mode=1, hours 23 then 00. Minutes and seconds unchanged; no tick advance for 50 cycles.
4. Set minute / exit: press mode (→SET_MIN), inc from 59 → 00 with hour unchanged; press mode → RUN, sec_bcd=8'h00.
5. Held button and collision: hold btn_inc 30 cycles in SET_HOUR → exactly one increment. Raise mode and inc edges in the same cycle → state advances, no increment.
6. Mid-set reset and blink: in SET_MIN, confirm blank[0] toggles every 4 cycles, then assert clr=0 → next cycle 00:00:00, mode=0, blank=00.
